// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR frame decoder: FSM states, pulse-width
// windows in microseconds, frame/counter sizes and small classification helpers.
package ir_pkg;

  localparam int CNT_W    = 16;
  localparam int NEC_BITS = 32;
  localparam int BITCNT_W = $clog2(NEC_BITS + 1);

  // Inclusive pulse-width windows, in microseconds.
  localparam logic [CNT_W-1:0] LEAD_M_MIN = 16'd8000;
  localparam logic [CNT_W-1:0] LEAD_M_MAX = 16'd10000;
  localparam logic [CNT_W-1:0] LEAD_S_MIN = 16'd4000;
  localparam logic [CNT_W-1:0] LEAD_S_MAX = 16'd5000;
  localparam logic [CNT_W-1:0] REP_S_MIN  = 16'd1800;
  localparam logic [CNT_W-1:0] REP_S_MAX  = 16'd2700;
  localparam logic [CNT_W-1:0] BIT_M_MIN  = 16'd400;
  localparam logic [CNT_W-1:0] BIT_M_MAX  = 16'd750;
  localparam logic [CNT_W-1:0] ZERO_S_MIN = 16'd400;
  localparam logic [CNT_W-1:0] ZERO_S_MAX = 16'd750;
  localparam logic [CNT_W-1:0] ONE_S_MIN  = 16'd1400;
  localparam logic [CNT_W-1:0] ONE_S_MAX  = 16'd1900;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LEAD_MARK   = 3'd1,
    LEAD_SPACE  = 3'd2,
    BIT_MARK    = 3'd3,
    BIT_SPACE   = 3'd4,
    REPEAT_STOP = 3'd5
  } ir_state_e;

  // True when an interval length falls inside an inclusive window.
  function automatic logic in_window(input logic [CNT_W-1:0] value,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

  // NEC integrity rule: the fourth byte is the bitwise inverse of the command.
  function automatic logic cmd_check_ok(input logic [NEC_BITS-1:0] frame);
    return frame[31:24] == ~frame[23:16];
  endfunction

endpackage

// File: rtl/ir_sync_edge.sv
// Brings the asynchronous, active-low IR receiver line into the clock domain,
// inverts it so that mark = 1, and produces registered one-cycle rise/fall
// pulses of the mark signal.
module ir_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ir_in,
  output logic rise,
  output logic fall
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic mark_s;

  // Two-flop synchronizer; resets to the idle (no carrier) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= ir_in;
      sync2_r <= sync1_r;
    end
  end

  assign mark_s = ~sync2_r;

  // Registered edge pulses: rise = mark start, fall = mark end.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      prev_r <= mark_s;
      rise   <= mark_s & ~prev_r;
      fall   <= ~mark_s & prev_r;
    end
  end

endmodule

// File: rtl/nec_frame_decoder.sv
// NEC IR frame decoder: measures mark/space lengths with a 1 us interval
// counter, decodes leader + 32 data bits + stop mark and NEC repeat codes,
// and emits one-cycle data_valid / repeat_pulse / frame_error strobes.
// Optional build macro IR_CMD_CHECK_EN: when defined, a frame whose top byte
// is not the inverse of its command byte is reported as frame_error.
module nec_frame_decoder
  import ir_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 12000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_in,
  output logic        data_valid,
  output logic        repeat_pulse,
  output logic        frame_error,
  output logic [15:0] address,
  output logic [7:0]  command,
  output logic        busy
);

  localparam int PRESC_DIV = CLK_HZ / 32'd1_000_000;
  localparam int PRESC_W   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  logic                rise_s;
  logic                fall_s;
  logic                edge_s;
  logic                tick_s;
  logic                timeout_s;
  logic                lead_m_s;
  logic                lead_s_s;
  logic                rep_s_s;
  logic                bit_m_s;
  logic                zero_s_s;
  logic                one_s_s;

  logic [PRESC_W-1:0]  presc_r;
  logic [CNT_W-1:0]    cnt_r;
  ir_state_e           state_r;
  logic [BITCNT_W-1:0] bitcnt_r;
  logic [NEC_BITS-1:0] shift_r;
  logic                have_frame_r;

  ir_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .ir_in (ir_in),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign edge_s = rise_s | fall_s;
  assign tick_s = (presc_r == PRESC_W'(PRESC_DIV - 1));

  // The timeout fires on the tick that brings the counter up to TIMEOUT_US.
  assign timeout_s = tick_s && (cnt_r == CNT_W'(TIMEOUT_US - 1));

  // Classification of the interval that ends on the current edge.
  assign lead_m_s = in_window(cnt_r, LEAD_M_MIN, LEAD_M_MAX);
  assign lead_s_s = in_window(cnt_r, LEAD_S_MIN, LEAD_S_MAX);
  assign rep_s_s  = in_window(cnt_r, REP_S_MIN,  REP_S_MAX);
  assign bit_m_s  = in_window(cnt_r, BIT_M_MIN,  BIT_M_MAX);
  assign zero_s_s = in_window(cnt_r, ZERO_S_MIN, ZERO_S_MAX);
  assign one_s_s  = in_window(cnt_r, ONE_S_MIN,  ONE_S_MAX);

  assign busy = (state_r != IDLE);

  // Microsecond prescaler and saturating interval counter, restarted on every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
      cnt_r   <= '0;
    end else if (edge_s) begin
      presc_r <= '0;
      cnt_r   <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
      if (cnt_r != {CNT_W{1'b1}}) begin
        cnt_r <= cnt_r + 16'd1;
      end
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

  // Frame FSM with registered strobes and held address/command words.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      bitcnt_r     <= '0;
      shift_r      <= '0;
      have_frame_r <= 1'b0;
      data_valid   <= 1'b0;
      repeat_pulse <= 1'b0;
      frame_error  <= 1'b0;
      address      <= 16'h0000;
      command      <= 8'h00;
    end else begin
      data_valid   <= 1'b0;
      repeat_pulse <= 1'b0;
      frame_error  <= 1'b0;
      if ((state_r != IDLE) && timeout_s) begin
        // A stalled frame is abandoned; this takes priority over a coincident edge.
        frame_error <= 1'b1;
        state_r     <= IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            if (rise_s) begin
              state_r <= LEAD_MARK;
            end
          end
          LEAD_MARK: begin
            if (fall_s) begin
              // A short mark is treated as noise and dropped without an error.
              state_r <= lead_m_s ? LEAD_SPACE : IDLE;
            end
          end
          LEAD_SPACE: begin
            if (rise_s) begin
              if (lead_s_s) begin
                bitcnt_r <= '0;
                state_r  <= BIT_MARK;
              end else if (rep_s_s) begin
                state_r <= REPEAT_STOP;
              end else begin
                frame_error <= 1'b1;
                state_r     <= IDLE;
              end
            end
          end
          BIT_MARK: begin
            if (fall_s) begin
              if (!bit_m_s) begin
                frame_error <= 1'b1;
                state_r     <= IDLE;
              end else if (bitcnt_r == BITCNT_W'(NEC_BITS)) begin
                // Stop mark of a complete frame.
`ifdef IR_CMD_CHECK_EN
                if (cmd_check_ok(shift_r)) begin
                  address      <= shift_r[15:0];
                  command      <= shift_r[23:16];
                  data_valid   <= 1'b1;
                  have_frame_r <= 1'b1;
                end else begin
                  frame_error <= 1'b1;
                end
`else
                address      <= shift_r[15:0];
                command      <= shift_r[23:16];
                data_valid   <= 1'b1;
                have_frame_r <= 1'b1;
`endif
                state_r <= IDLE;
              end else begin
                state_r <= BIT_SPACE;
              end
            end
          end
          BIT_SPACE: begin
            if (rise_s) begin
              if (zero_s_s || one_s_s) begin
                // Bits arrive LSB first, so shift in from the top.
                shift_r  <= {one_s_s, shift_r[NEC_BITS-1:1]};
                bitcnt_r <= bitcnt_r + BITCNT_W'(1);
                state_r  <= BIT_MARK;
              end else begin
                frame_error <= 1'b1;
                state_r     <= IDLE;
              end
            end
          end
          REPEAT_STOP: begin
            if (fall_s) begin
              if (bit_m_s && have_frame_r) begin
                repeat_pulse <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
              state_r <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nec_frame_decoder.sv
// Scoreboard bench for nec_frame_decoder at CLK_HZ = 1 MHz (1 cycle = 1 us).
// Stimulus pushes the expected strobe; a negedge monitor pops and compares.
module tb_nec_frame_decoder;

  localparam int K_VALID = 0;
  localparam int K_REP   = 1;
  localparam int K_ERR   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ir_in;
  logic        data_valid;
  logic        repeat_pulse;
  logic        frame_error;
  logic [15:0] address;
  logic [7:0]  command;
  logic        busy;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [7:0]  cmd;
    longint      at;
  } exp_t;

  exp_t sb[$];

  nec_frame_decoder #(
    .CLK_HZ     (1_000_000),
    .TIMEOUT_US (12000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ir_in        (ir_in),
    .data_valid   (data_valid),
    .repeat_pulse (repeat_pulse),
    .frame_error  (frame_error),
    .address      (address),
    .command      (command),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] a, input logic [7:0] c,
                           input longint at);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.cmd  = c;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest expected event.
  int   mon_cnt;
  int   mon_kind;
  exp_t mon_e;
  always @(negedge clk) begin
    mon_cnt = int'(data_valid) + int'(repeat_pulse) + int'(frame_error);
    if (mon_cnt != 0) begin
      check("one_strobe", mon_cnt, 1);
      mon_kind = data_valid ? K_VALID : (repeat_pulse ? K_REP : K_ERR);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: actual kind %0d at cycle %0d required none",
                 mon_kind, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind", mon_kind, mon_e.kind);
        check("address", address, mon_e.addr);
        check("command", command, mon_e.cmd);
        if (mon_e.at >= 0) check("strobe_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic seg(input logic lvl, input int n);
    ir_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark(input int n);  seg(1'b0, n); endtask
  task automatic space(input int n); seg(1'b1, n); endtask

  task automatic send_bit(input logic b);
    mark(560);
    space(b ? 1690 : 560);
  endtask

  task automatic send_frame(input logic [31:0] f);
    mark(9000);
    space(4500);
    for (int i = 0; i < 32; i++) send_bit(f[i]);
    mark(560);
    space(100);
  endtask

  task automatic send_repeat();
    mark(9000);
    space(2250);
    mark(560);
    space(100);
  endtask

  task automatic drain(input int limit);
    int b = 0;
    while (sb.size() != 0 && b < limit) begin
      @(posedge clk);
      b++;
    end
    #1;
    check("drain_queue", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_repeat_pulse"}, repeat_pulse, 0);
    check({tag, "_frame_error"}, frame_error, 0);
    check({tag, "_address"}, address, 0);
    check({tag, "_command"}, command, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  logic [31:0] f_good;
  logic [31:0] f_bad;

  initial begin
    f_good = 32'hF708FB04;
    f_bad  = 32'hF608FB04;
    reset  = 1'b1;
    ir_in  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset");
    space(50);

    // Repeat code with no prior frame.
    expect_ev(K_ERR, 16'h0000, 8'h00, -1);
    send_repeat();
    drain(1000);

    // Short glitch mark is silently ignored.
    mark(200);
    space(300);
    drain(10);

    // Leader space of 3000 us is malformed.
    expect_ev(K_ERR, 16'h0000, 8'h00, -1);
    mark(9000);
    space(3000);
    mark(560);
    space(100);
    drain(1000);

    // Valid frame 04 FB 08 F7.
    expect_ev(K_VALID, 16'hFB04, 8'h08, -1);
    send_frame(f_good);
    drain(1000);
    check("busy_after_frame", busy, 0);

    // Repeat after a valid frame keeps address/command.
    expect_ev(K_REP, 16'hFB04, 8'h08, -1);
    send_repeat();
    drain(1000);
    check("addr_after_repeat", address, 16'hFB04);
    check("cmd_after_repeat", command, 8'h08);

    // Leader + 10 bit marks, then line left idle: timeout 12000 us after the last edge.
    mark(9000);
    space(4500);
    for (int i = 0; i < 9; i++) send_bit(f_good[i]);
    mark(560);
    ir_in = 1'b1;
    expect_ev(K_ERR, 16'hFB04, 8'h08, cyc + 12004);
    drain(20000);
    check("busy_after_timeout", busy, 0);
    space(100);

    // Reset pulse during bit 17 aborts the frame with no strobe.
    mark(9000);
    space(4500);
    for (int i = 0; i < 17; i++) send_bit(f_good[i]);
    ir_in = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("midreset");
    repeat (360) @(posedge clk);
    #1;
    space(500);
    drain(10);

    // Frame 04 FB 08 F6: integrity check decides the outcome.
`ifdef IR_CMD_CHECK_EN
    expect_ev(K_ERR, 16'h0000, 8'h00, -1);
`else
    expect_ev(K_VALID, 16'hFB04, 8'h08, -1);
`endif
    send_frame(f_bad);
    drain(1000);
    check("busy_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
